// File: rtl/svarog_ahb_pkg.sv
// ==========================================================================
// svarog_ahb_pkg -- shared AHB-Lite encodings and address-phase bundle | rev 1.0
// ==========================================================================
`default_nettype none

package svarog_ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   localparam int AHB_ADDR_WIDTH = 32;

   typedef struct packed {
      logic [AHB_ADDR_WIDTH-1:0] haddr;
      logic                      hwrite;
      logic [2:0]                hsize;
   } ahb_aphase_t;

   // BUSY counts as IDLE and SEQ as NONSEQ: only bit 1 carries a request.
   function automatic logic is_active(input logic [1:0] htrans);
      return htrans[1];
   endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_addr_hold.sv
// ==========================================================================
// ahb_addr_hold -- per-master address hold register, candidate mux, stall | rev 1.0
// ==========================================================================
`default_nettype none

module ahb_addr_hold
   import svarog_ahb_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  htrans,
   input  ahb_aphase_t req,
   input  logic        bus_ready,
   input  logic        dphase_own,
   input  logic        granted,
   output logic        ready,
   output logic        cand_vld,
   output ahb_aphase_t cand
);

   logic        hold_vld;
   ahb_aphase_t hold;
   logic        accept;

   // A master never owns the data phase while it also holds a request, so
   // checking ownership first is enough to cover all three stall cases.
   always_comb begin
      ready    = dphase_own ? bus_ready : ~hold_vld;
      accept   = ready & is_active(htrans) & rst_n;
      cand_vld = hold_vld | accept;
      cand     = hold_vld ? hold : req;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_vld <= 1'b0;
         hold     <= '0;
      end else if (granted) begin
         hold_vld <= 1'b0;
      end else if (accept) begin
         hold_vld <= 1'b1;
         hold     <= req;
      end
   end

endmodule

`default_nettype wire

// File: rtl/ahb_master_arbiter.sv
// ==========================================================================
// ahb_master_arbiter -- round-robin ibus/dbus share of one AHB-Lite bus | rev 1.0
// ==========================================================================
`default_nettype none

module ahb_master_arbiter
   import svarog_ahb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter bit DBUS_FIRST = 1'b1
)(
   input  logic                  hclk_i,
   input  logic                  hresetn_i,

   input  logic [1:0]            ibus_htrans_i,
   input  logic [ADDR_WIDTH-1:0] ibus_haddr_i,
   input  logic                  ibus_hwrite_i,
   input  logic [2:0]            ibus_hsize_i,
   input  logic [DATA_WIDTH-1:0] ibus_hwdata_i,
   output logic [DATA_WIDTH-1:0] ibus_hrdata_o,
   output logic                  ibus_hready_o,
   output logic                  ibus_hresp_o,

   input  logic [1:0]            dbus_htrans_i,
   input  logic [ADDR_WIDTH-1:0] dbus_haddr_i,
   input  logic                  dbus_hwrite_i,
   input  logic [2:0]            dbus_hsize_i,
   input  logic [DATA_WIDTH-1:0] dbus_hwdata_i,
   output logic [DATA_WIDTH-1:0] dbus_hrdata_o,
   output logic                  dbus_hready_o,
   output logic                  dbus_hresp_o,

   output logic [1:0]            htrans_o,
   output logic [ADDR_WIDTH-1:0] haddr_o,
   output logic                  hwrite_o,
   output logic [2:0]            hsize_o,
   output logic [DATA_WIDTH-1:0] hwdata_o,
   input  logic [DATA_WIDTH-1:0] hrdata_i,
   input  logic                  hready_i,
   input  logic                  hresp_i
);

   ahb_aphase_t ibus_req, dbus_req, ibus_cand, dbus_cand, sel_req;
   logic        ibus_cand_vld, dbus_cand_vld;
   logic        ibus_own, dbus_own;
   logic        ibus_grant, dbus_grant;
   logic        sel_vld, sel_dbus, issue;

   logic        last_dbus;
   logic        dphase_vld, dphase_dbus;
   logic        shown_vld, shown_dbus;

   always_comb begin
      ibus_req.haddr  = AHB_ADDR_WIDTH'(ibus_haddr_i);
      ibus_req.hwrite = ibus_hwrite_i;
      ibus_req.hsize  = ibus_hsize_i;
      dbus_req.haddr  = AHB_ADDR_WIDTH'(dbus_haddr_i);
      dbus_req.hwrite = dbus_hwrite_i;
      dbus_req.hsize  = dbus_hsize_i;
      ibus_own        = dphase_vld & ~dphase_dbus;
      dbus_own        = dphase_vld &  dphase_dbus;
   end

   ahb_addr_hold u_ibus_hold (
      .clk        (hclk_i),
      .rst_n      (hresetn_i),
      .htrans     (ibus_htrans_i),
      .req        (ibus_req),
      .bus_ready  (hready_i),
      .dphase_own (ibus_own),
      .granted    (ibus_grant),
      .ready      (ibus_hready_o),
      .cand_vld   (ibus_cand_vld),
      .cand       (ibus_cand)
   );

   ahb_addr_hold u_dbus_hold (
      .clk        (hclk_i),
      .rst_n      (hresetn_i),
      .htrans     (dbus_htrans_i),
      .req        (dbus_req),
      .bus_ready  (hready_i),
      .dphase_own (dbus_own),
      .granted    (dbus_grant),
      .ready      (dbus_hready_o),
      .cand_vld   (dbus_cand_vld),
      .cand       (dbus_cand)
   );

   // Once a candidate has been shown during a wait state it stays selected,
   // so the shared address phase cannot switch masters under hready_i=0.
   always_comb begin
      if (shown_vld)
         sel_dbus = shown_dbus;
      else if (ibus_cand_vld & dbus_cand_vld)
         sel_dbus = ~last_dbus;
      else
         sel_dbus = dbus_cand_vld;
      sel_vld    = shown_vld | ibus_cand_vld | dbus_cand_vld;
      sel_req    = sel_dbus ? dbus_cand : ibus_cand;
      issue      = sel_vld & hready_i;
      ibus_grant = issue & ~sel_dbus;
      dbus_grant = issue &  sel_dbus;
   end

   always_ff @(posedge hclk_i or negedge hresetn_i) begin
      if (!hresetn_i) begin
         last_dbus   <= ~DBUS_FIRST;
         dphase_vld  <= 1'b0;
         dphase_dbus <= 1'b0;
         shown_vld   <= 1'b0;
         shown_dbus  <= 1'b0;
      end else if (hready_i) begin
         dphase_vld  <= issue;
         dphase_dbus <= sel_dbus;
         shown_vld   <= 1'b0;
         if (issue)
            last_dbus <= sel_dbus;
      end else begin
         shown_vld   <= sel_vld;
         shown_dbus  <= sel_dbus;
      end
   end

   always_comb begin
      htrans_o      = sel_vld ? HTRANS_NONSEQ : HTRANS_IDLE;
      haddr_o       = sel_vld ? ADDR_WIDTH'(sel_req.haddr) : '0;
      hwrite_o      = sel_vld ? sel_req.hwrite : 1'b0;
      hsize_o       = sel_vld ? sel_req.hsize : 3'd0;
      hwdata_o      = dphase_dbus ? dbus_hwdata_i : ibus_hwdata_i;
      ibus_hrdata_o = hrdata_i;
      dbus_hrdata_o = hrdata_i;
      ibus_hresp_o  = ibus_own ? hresp_i : HRESP_OKAY;
      dbus_hresp_o  = dbus_own ? hresp_i : HRESP_OKAY;
   end

endmodule

`default_nettype wire

// File: tb/tb_ahb_master_arbiter.sv
// ==========================================================================
// tb_ahb_master_arbiter -- scenario bench with per-master issue scoreboard | rev 1.0
// ==========================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ahb_master_arbiter;
   import svarog_ahb_pkg::*;

   localparam int DW = 32;
   localparam int AW = 32;

   logic          hclk = 1'b0;
   logic          hresetn = 1'b0;
   logic [1:0]    ibus_htrans, dbus_htrans;
   logic [AW-1:0] ibus_haddr, dbus_haddr;
   logic          ibus_hwrite, dbus_hwrite;
   logic [2:0]    ibus_hsize, dbus_hsize;
   logic [DW-1:0] ibus_hwdata, dbus_hwdata, ibus_hrdata, dbus_hrdata;
   logic          ibus_hready, dbus_hready, ibus_hresp, dbus_hresp;
   logic [1:0]    htrans;
   logic [AW-1:0] haddr;
   logic          hwrite;
   logic [2:0]    hsize;
   logic [DW-1:0] hwdata, hrdata;
   logic          hready, hresp;

   int            total = 0;
   int            passed = 0;
   logic [35:0]   exp_i[$];
   logic [35:0]   exp_d[$];
   logic [35:0]   mon_got, mon_want;

   always #5 hclk = ~hclk;

   ahb_master_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DBUS_FIRST(1'b1)) dut (
      .hclk_i        (hclk),
      .hresetn_i     (hresetn),
      .ibus_htrans_i (ibus_htrans),
      .ibus_haddr_i  (ibus_haddr),
      .ibus_hwrite_i (ibus_hwrite),
      .ibus_hsize_i  (ibus_hsize),
      .ibus_hwdata_i (ibus_hwdata),
      .ibus_hrdata_o (ibus_hrdata),
      .ibus_hready_o (ibus_hready),
      .ibus_hresp_o  (ibus_hresp),
      .dbus_htrans_i (dbus_htrans),
      .dbus_haddr_i  (dbus_haddr),
      .dbus_hwrite_i (dbus_hwrite),
      .dbus_hsize_i  (dbus_hsize),
      .dbus_hwdata_i (dbus_hwdata),
      .dbus_hrdata_o (dbus_hrdata),
      .dbus_hready_o (dbus_hready),
      .dbus_hresp_o  (dbus_hresp),
      .htrans_o      (htrans),
      .haddr_o       (haddr),
      .hwrite_o      (hwrite),
      .hsize_o       (hsize),
      .hwdata_o      (hwdata),
      .hrdata_i      (hrdata),
      .hready_i      (hready),
      .hresp_i       (hresp)
   );

   // Every accepted shared address phase is matched against its master's queue.
   always @(negedge hclk) begin
      if (hresetn && hready && htrans == HTRANS_NONSEQ) begin
         mon_got = {haddr, hwrite, hsize};
         total++;
         if (haddr[31:24] == 8'h01) begin
            if (exp_i.size() == 0)
               $display("FAIL issue_ibus unexpected got=%h", mon_got);
            else begin
               mon_want = exp_i.pop_front();
               if (mon_got !== mon_want) $display("FAIL issue_ibus got=%h want=%h", mon_got, mon_want);
               else passed++;
            end
         end else begin
            if (exp_d.size() == 0)
               $display("FAIL issue_dbus unexpected got=%h", mon_got);
            else begin
               mon_want = exp_d.pop_front();
               if (mon_got !== mon_want) $display("FAIL issue_dbus got=%h want=%h", mon_got, mon_want);
               else passed++;
            end
         end
      end
   end

   task automatic cyc();
      @(posedge hclk);
      #1;
   endtask

   task automatic idle_masters();
      ibus_htrans = HTRANS_IDLE; ibus_haddr = '0; ibus_hwrite = 1'b0; ibus_hsize = 3'd0;
      dbus_htrans = HTRANS_IDLE; dbus_haddr = '0; dbus_hwrite = 1'b0; dbus_hsize = 3'd0;
   endtask

   task automatic drive_ibus(input logic [31:0] a);
      ibus_htrans = HTRANS_NONSEQ; ibus_haddr = a; ibus_hwrite = 1'b0; ibus_hsize = 3'd2;
      exp_i.push_back({a, 1'b0, 3'd2});
   endtask

   task automatic drive_dbus(input logic [31:0] a, input logic w);
      dbus_htrans = HTRANS_NONSEQ; dbus_haddr = a; dbus_hwrite = w; dbus_hsize = 3'd2;
      exp_d.push_back({a, w, 3'd2});
   endtask

   task automatic test_reset();
      idle_masters();
      ibus_hwdata = '0; dbus_hwdata = '0;
      hready = 1'b1; hresp = HRESP_OKAY; hrdata = '0;
      hresetn = 1'b0;
      ibus_htrans = HTRANS_NONSEQ; ibus_haddr = 32'h0100_0000; ibus_hwrite = 1'b1; ibus_hsize = 3'd2;
      repeat (2) @(posedge hclk);
      @(negedge hclk);
      total++; if (htrans !== HTRANS_IDLE) $display("FAIL rst_htrans got=%b want=00", htrans); else passed++;
      total++; if (haddr !== 32'h0) $display("FAIL rst_haddr got=%h want=0", haddr); else passed++;
      total++; if (hwrite !== 1'b0 || hsize !== 3'd0) $display("FAIL rst_hwrite_hsize got=%b/%0d want=0/0", hwrite, hsize); else passed++;
      total++; if (ibus_hready !== 1'b1 || dbus_hready !== 1'b1) $display("FAIL rst_hready got=%b%b want=11", ibus_hready, dbus_hready); else passed++;
      total++; if (ibus_hresp !== 1'b0 || dbus_hresp !== 1'b0) $display("FAIL rst_hresp got=%b%b want=00", ibus_hresp, dbus_hresp); else passed++;
      idle_masters();
      @(posedge hclk); #1;
      hresetn = 1'b1;
   endtask

   task automatic test_lone_ibus();
      cyc(); drive_ibus(32'h0100_0010);
      @(negedge hclk);
      total++; if (htrans !== HTRANS_NONSEQ) $display("FAIL t1_htrans got=%b want=10", htrans); else passed++;
      total++; if (dbus_hready !== 1'b1) $display("FAIL t1_dbus_ready_a got=%b want=1", dbus_hready); else passed++;
      cyc(); idle_masters(); hrdata = 32'hCAFE_0001;
      @(negedge hclk);
      total++; if (ibus_hrdata !== 32'hCAFE_0001) $display("FAIL t1_hrdata got=%h want=cafe0001", ibus_hrdata); else passed++;
      total++; if (ibus_hready !== 1'b1 || dbus_hready !== 1'b1) $display("FAIL t1_ready_b got=%b%b want=11", ibus_hready, dbus_hready); else passed++;
      total++; if (htrans !== HTRANS_IDLE) $display("FAIL t1_idle got=%b want=00", htrans); else passed++;
      cyc(); hrdata = '0;
   endtask

   task automatic test_contention();
      cyc(); drive_dbus(32'h0200_0000, 1'b0);
      cyc(); drive_dbus(32'h0200_0004, 1'b1); drive_ibus(32'h0100_0020);
      @(negedge hclk);
      total++; if (haddr !== 32'h0100_0020) $display("FAIL t2_first_ibus got=%h want=01000020", haddr); else passed++;
      total++; if (dbus_hready !== 1'b1) $display("FAIL t2_dbus_accept got=%b want=1", dbus_hready); else passed++;
      cyc(); idle_masters(); dbus_hwdata = 32'hDEAD_BEEF;
      @(negedge hclk);
      total++; if (haddr !== 32'h0200_0004 || hwrite !== 1'b1) $display("FAIL t2_held_dbus got=%h/%b want=02000004/1", haddr, hwrite); else passed++;
      total++; if (dbus_hready !== 1'b0 || ibus_hready !== 1'b1) $display("FAIL t2_stall got=%b%b want=10", ibus_hready, dbus_hready); else passed++;
      cyc();
      @(negedge hclk);
      total++; if (hwdata !== 32'hDEAD_BEEF) $display("FAIL t2_hwdata got=%h want=deadbeef", hwdata); else passed++;
      total++; if (dbus_hready !== 1'b1) $display("FAIL t2_dbus_done got=%b want=1", dbus_hready); else passed++;
      cyc(); dbus_hwdata = '0;
   endtask

   task automatic test_wait_states();
      cyc(); drive_dbus(32'h0200_0008, 1'b0);
      cyc(); idle_masters(); hready = 1'b0; drive_ibus(32'h0100_0030);
      @(negedge hclk);
      total++; if (haddr !== 32'h0100_0030) $display("FAIL t3_addr_w0 got=%h want=01000030", haddr); else passed++;
      total++; if (dbus_hready !== 1'b0 || ibus_hready !== 1'b1) $display("FAIL t3_ready_w0 got=%b%b want=10", ibus_hready, dbus_hready); else passed++;
      for (int k = 1; k < 3; k++) begin
         cyc(); idle_masters();
         @(negedge hclk);
         total++; if (haddr !== 32'h0100_0030 || htrans !== HTRANS_NONSEQ) $display("FAIL t3_addr_w%0d got=%h/%b want=01000030/10", k, haddr, htrans); else passed++;
         total++; if (ibus_hready !== 1'b0) $display("FAIL t3_ibus_stall_w%0d got=%b want=0", k, ibus_hready); else passed++;
      end
      cyc(); hready = 1'b1; hrdata = 32'h0000_1234;
      @(negedge hclk);
      total++; if (dbus_hready !== 1'b1 || dbus_hrdata !== 32'h0000_1234) $display("FAIL t3_dbus_done got=%b/%h want=1/00001234", dbus_hready, dbus_hrdata); else passed++;
      total++; if (ibus_hready !== 1'b0 || haddr !== 32'h0100_0030) $display("FAIL t3_ibus_issue got=%b/%h want=0/01000030", ibus_hready, haddr); else passed++;
      cyc(); hrdata = '0;
      @(negedge hclk);
      total++; if (ibus_hready !== 1'b1) $display("FAIL t3_ibus_done got=%b want=1", ibus_hready); else passed++;
      cyc();
   endtask

   task automatic test_error();
      cyc(); drive_dbus(32'h0400_0000, 1'b0);
      cyc(); idle_masters(); hready = 1'b0; hresp = HRESP_ERROR; drive_ibus(32'h0100_0040);
      @(negedge hclk);
      total++; if (dbus_hresp !== 1'b1 || ibus_hresp !== 1'b0) $display("FAIL t4_err1 got=%b%b want=01", ibus_hresp, dbus_hresp); else passed++;
      total++; if (dbus_hready !== 1'b0) $display("FAIL t4_err1_ready got=%b want=0", dbus_hready); else passed++;
      cyc(); idle_masters(); hready = 1'b1;
      @(negedge hclk);
      total++; if (dbus_hresp !== 1'b1 || ibus_hresp !== 1'b0) $display("FAIL t4_err2 got=%b%b want=01", ibus_hresp, dbus_hresp); else passed++;
      total++; if (dbus_hready !== 1'b1 || ibus_hready !== 1'b0) $display("FAIL t4_err2_ready got=%b%b want=01", ibus_hready, dbus_hready); else passed++;
      cyc(); hresp = HRESP_OKAY;
      @(negedge hclk);
      total++; if (ibus_hready !== 1'b1 || ibus_hresp !== 1'b0) $display("FAIL t4_ibus_ok got=%b/%b want=1/0", ibus_hready, ibus_hresp); else passed++;
      cyc();
   endtask

   task automatic test_back_to_back();
      int  i_idx, d_idx, n_issue;
      bit  i_acc, d_acc, cur_d, want_d;
      i_idx = 0; d_idx = 0; n_issue = 0;
      cyc(); drive_ibus(32'h0100_1000); drive_dbus(32'h0200_1000, 1'b1);
      for (int c = 0; c < 8; c++) begin
         @(negedge hclk);
         i_acc = (ibus_htrans == HTRANS_NONSEQ) && ibus_hready;
         d_acc = (dbus_htrans == HTRANS_NONSEQ) && dbus_hready;
         if (htrans == HTRANS_NONSEQ) begin
            cur_d  = (haddr[31:24] == 8'h02);
            want_d = (n_issue % 2 == 0);
            total++; if (cur_d !== want_d) $display("FAIL t5_alternate_%0d got_dbus=%b want_dbus=%b", n_issue, cur_d, want_d); else passed++;
            n_issue++;
         end
         @(posedge hclk); #1;
         if (i_acc) begin
            i_idx++;
            if (i_idx < 4) drive_ibus(32'h0100_1000 + 32'(i_idx * 4));
            else ibus_htrans = HTRANS_IDLE;
         end
         if (d_acc) begin
            d_idx++;
            if (d_idx < 4) drive_dbus(32'h0200_1000 + 32'(d_idx * 4), 1'b1);
            else dbus_htrans = HTRANS_IDLE;
         end
      end
      total++; if (n_issue !== 8) $display("FAIL t5_issue_count got=%0d want=8", n_issue); else passed++;
      idle_masters();
      cyc();
   endtask

   task automatic test_reset_mid();
      cyc(); drive_dbus(32'h0200_0010, 1'b0);
      cyc(); idle_masters(); hready = 1'b0; drive_ibus(32'h0100_0050);
      cyc(); idle_masters();
      #2 hresetn = 1'b0;
      #1;
      total++; if (htrans !== HTRANS_IDLE || haddr !== 32'h0) $display("FAIL t6_rst_bus got=%b/%h want=00/0", htrans, haddr); else passed++;
      total++; if (ibus_hready !== 1'b1 || dbus_hready !== 1'b1) $display("FAIL t6_rst_ready got=%b%b want=11", ibus_hready, dbus_hready); else passed++;
      total++; if (dbus_hresp !== 1'b0) $display("FAIL t6_rst_hresp got=%b want=0", dbus_hresp); else passed++;
      exp_i.delete();
      hready = 1'b1;
      @(posedge hclk); #1;
      hresetn = 1'b1;
      drive_ibus(32'h0100_0060); drive_dbus(32'h0200_0020, 1'b0);
      @(negedge hclk);
      total++; if (haddr !== 32'h0200_0020) $display("FAIL t6_first_tie got=%h want=02000020", haddr); else passed++;
      cyc(); idle_masters();
      @(negedge hclk);
      total++; if (haddr !== 32'h0100_0060) $display("FAIL t6_second got=%h want=01000060", haddr); else passed++;
      cyc(); cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_lone_ibus();
      test_contention();
      test_wait_states();
      test_error();
      test_back_to_back();
      test_reset_mid();
      total++;
      if (exp_i.size() != 0 || exp_d.size() != 0)
         $display("FAIL scoreboard_drain got=%0d/%0d want=0/0", exp_i.size(), exp_d.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
